// File: rtl/fir_mac_filter.sv
// Single-MAC FIR filter for signed Q1.23 audio. Each accepted sample triggers one
// NTAPS-long convolution through a two-stage read/multiply pipeline, then one output strobe.
module fir_mac_filter #(
  parameter int                  NTAPS     = 32,
  parameter logic [NTAPS*24-1:0] COEF_INIT = {NTAPS{24'h010000}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [23:0] din,
  input  logic               din_valid,
  output logic signed [23:0] dout,
  output logic               dout_valid
);

  localparam int AW   = $clog2(NTAPS);
  localparam int CW   = AW + 1;
  localparam int ACCW = 48 + AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(8388607);
  localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - 1;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [AW-1:0]          r_wr_ptr;
  logic signed [23:0]     r_delay [NTAPS];
  logic signed [23:0]     r_samp;
  logic signed [23:0]     r_coef;
  logic                   r_v1;
  logic                   r_v2;
  logic signed [47:0]     r_prod;
  logic signed [ACCW-1:0] r_acc;
  logic signed [23:0]     r_dout;
  logic                   r_dout_valid;

  logic signed [23:0]     w_coef [NTAPS];
  logic                   w_issue;
  logic [AW-1:0]          w_rd_addr;
  logic signed [ACCW-1:0] w_shift;
  logic signed [23:0]     w_dout_next;

  // c[k] occupies bits [k*24 +: 24] of the packed coefficient image
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
      assign w_coef[gi] = COEF_INIT[gi*24 +: 24];
    end
  endgenerate

  assign w_issue   = (r_state == S_MAC) && (r_cnt < CW'(NTAPS));
  assign w_rd_addr = r_wr_ptr - r_cnt[AW-1:0];
  assign w_shift   = r_acc >>> 23;

  always_comb begin
    w_dout_next = w_shift[23:0];
    if (w_shift > SAT_MAX)
      w_dout_next = 24'sh7FFFFF;
    else if (w_shift < SAT_MIN)
      w_dout_next = 24'sh800000;
  end

  // MAC stays active two extra cycles so the read and multiply stages drain into r_acc
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_samp       <= '0;
      r_coef       <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_delay[i] <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      r_v1         <= w_issue;
      r_v2         <= r_v1;
      if (w_issue) begin
        r_samp <= r_delay[w_rd_addr];
        r_coef <= w_coef[r_cnt[AW-1:0]];
      end
      if (r_v1) r_prod <= r_samp * r_coef;

      case (r_state)
        S_IDLE: begin
          if (din_valid) begin
            r_delay[r_wr_ptr] <= din;
            r_acc             <= '0;
            r_cnt             <= '0;
            r_state           <= S_MAC;
          end
        end
        S_MAC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_v2) r_acc <= r_acc + ACCW'(r_prod);
          if (r_cnt == CW'(NTAPS + 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_dout       <= w_dout_next;
          r_dout_valid <= 1'b1;
          r_wr_ptr     <= r_wr_ptr + AW'(1);
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: NTAPS=32, c[k]=(k+1)*0x010000, checked against
// a direct-form convolution model over the history of accepted samples.
module tb_fir_mac_filter;

  localparam int NT  = 32;
  localparam int LAT = NT + 3;

  function automatic logic [NT*24-1:0] make_coefs();
    logic [NT*24-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++) v[k*24 +: 24] = 24'((k + 1) * 32'h10000);
    return v;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        din_valid = 1'b0;
  logic [23:0] dout;
  logic        dout_valid;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [23:0] hist   [NT];
  logic signed [23:0] coef_m [NT];

  fir_mac_filter #(.NTAPS(NT), .COEF_INIT(make_coefs())) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < NT; k++) hist[k] = '0;
  endtask

  task automatic model_push(input logic [23:0] s, output logic [23:0] e);
    longint acc;
    longint sh;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(coef_m[k]) * longint'(hist[k]);
    sh = acc >>> 23;
    if (sh > 64'sd8388607)       e = 24'h7FFFFF;
    else if (sh < -64'sd8388608) e = 24'h800000;
    else                         e = sh[23:0];
  endtask

  // Drives one sample, then watches a bounded window for the result strobe.
  task automatic send(input logic [23:0] s, output logic [23:0] got, output int lat, output int np);
    @(negedge clk);
    din = s;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = '0;
    got = '0;
    lat = -1;
    np = dout_valid ? 1 : 0;
    for (int i = 1; i <= NT + 6; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        np++;
        if (lat < 0) begin
          lat = i;
          got = dout;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] got, e;
    int lat, np;
    rst = 1'b1;
    din_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (dout !== 24'h0) $display("FAIL reset_dout: got %h expected 000000", dout); else n_pass++;
    n_total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dout_valid); else n_pass++;
    rst = 1'b0;
    model_clear();
    send(24'h0, got, lat, np);
    model_push(24'h0, e);
    $display("reset: din=000000 dout=%h exp=%h lat=%0d pulses=%0d", got, e, lat, np);
    n_total++; if (got !== e) $display("FAIL reset_first: dout=%h expected %h", got, e); else n_pass++;
    n_total++; if (lat != LAT) $display("FAIL reset_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (np != 1) $display("FAIL reset_pulses: got %0d expected 1", np); else n_pass++;
  endtask

  // Impulse of 0.5: the n-th output after it is c[n]>>>1 = (n+1)*0x8000, then zero.
  task automatic run_impulse(input string tag, input int lead);
    logic [23:0] got, e, ideal, s;
    int lat, np, n;
    for (int j = 0; j < lead + NT + 2; j++) begin
      s = (j == lead) ? 24'h400000 : 24'h0;
      send(s, got, lat, np);
      model_push(s, e);
      n = j - lead;
      ideal = (n >= 0 && n < NT) ? 24'((n + 1) * 32'h8000) : 24'h0;
      $display("%s[%0d]: din=%h dout=%h exp=%h lat=%0d", tag, j, s, got, ideal, lat);
      n_total++; if (got !== ideal) $display("FAIL %s[%0d]: dout=%h expected %h", tag, j, got, ideal); else n_pass++;
      n_total++; if (got !== e) $display("FAIL %s_model[%0d]: dout=%h expected %h", tag, j, got, e); else n_pass++;
      n_total++; if (lat != LAT || np != 1) $display("FAIL %s_timing[%0d]: lat=%0d pulses=%0d expected %0d/1", tag, j, lat, np, LAT); else n_pass++;
    end
  endtask

  task automatic test_impulse();
    run_impulse("impulse", 3);
  endtask

  task automatic test_step();
    logic [23:0] got, e;
    int lat, np;
    for (int j = 0; j < NT + 8; j++) begin
      send(24'h100000, got, lat, np);
      model_push(24'h100000, e);
      $display("step[%0d]: din=100000 dout=%h exp=%h lat=%0d", j, got, e, lat);
      n_total++; if (got !== e || lat != LAT) $display("FAIL step[%0d]: dout=%h lat=%0d expected %h lat=%0d", j, got, lat, e, LAT); else n_pass++;
    end
    n_total++; if (got !== 24'h420000) $display("FAIL step_settle: dout=%h expected 420000", got); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [23:0] got, e, s;
    int lat, np;
    for (int p = 0; p < 2; p++) begin
      s = (p == 0) ? 24'h7FFFFF : 24'h800000;
      for (int j = 0; j < NT + 2; j++) begin
        send(s, got, lat, np);
        model_push(s, e);
        $display("sat[%0d][%0d]: din=%h dout=%h exp=%h lat=%0d", p, j, s, got, e, lat);
        n_total++; if (got !== e) $display("FAIL sat[%0d][%0d]: dout=%h expected %h", p, j, got, e); else n_pass++;
      end
      n_total++; if (got !== s) $display("FAIL sat_clamp[%0d]: dout=%h expected %h", p, got, s); else n_pass++;
    end
  endtask

  task automatic test_dropped();
    logic [23:0] a, b, c, got, e;
    int lat, np;
    a = 24'($urandom());
    b = 24'($urandom());
    c = 24'($urandom());
    @(negedge clk);
    din = a;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    got = '0;
    lat = -1;
    np = dout_valid ? 1 : 0;
    for (int i = 1; i <= NT + 6; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        np++;
        if (lat < 0) begin
          lat = i;
          got = dout;
        end
      end
      if (i == 4) begin
        din = b;
        din_valid = 1'b1;
      end else if (i == 5) begin
        din_valid = 1'b0;
      end
    end
    model_push(a, e);
    $display("dropped: din=%h extra=%h dout=%h exp=%h lat=%0d pulses=%0d", a, b, got, e, lat, np);
    n_total++; if (np != 1) $display("FAIL dropped_pulses: got %0d expected 1", np); else n_pass++;
    n_total++; if (lat != LAT) $display("FAIL dropped_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (got !== e) $display("FAIL dropped_value: dout=%h expected %h", got, e); else n_pass++;
    send(c, got, lat, np);
    model_push(c, e);
    $display("dropped_next: din=%h dout=%h exp=%h lat=%0d", c, got, e, lat);
    n_total++; if (got !== e) $display("FAIL dropped_next: dout=%h expected %h", got, e); else n_pass++;
  endtask

  task automatic test_random();
    logic [23:0] got, e, s;
    int lat, np;
    for (int j = 0; j < 30; j++) begin
      s = 24'($urandom());
      send(s, got, lat, np);
      model_push(s, e);
      $display("random[%0d]: din=%h dout=%h exp=%h lat=%0d", j, s, got, e, lat);
      n_total++; if (got !== e || np != 1) $display("FAIL random[%0d]: dout=%h pulses=%0d expected %h/1", j, got, np, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mac();
    int np;
    @(negedge clk);
    din = 24'h400000;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = '0;
    np = 0;
    for (int i = 1; i <= NT + 6; i++) begin
      @(negedge clk);
      if (dout_valid) np++;
      if (i == 10) rst = 1'b1;
      else if (i == 13) rst = 1'b0;
    end
    $display("reset_mid_mac: din=400000 pulses=%0d", np);
    n_total++; if (np != 0) $display("FAIL reset_mid_mac_pulses: got %0d expected 0", np); else n_pass++;
    model_clear();
    run_impulse("post_reset", 0);
  endtask

  initial begin
    for (int k = 0; k < NT; k++) coef_m[k] = 24'((k + 1) * 32'h10000);
    model_clear();
    test_reset();
    test_impulse();
    test_step();
    test_saturation();
    test_dropped();
    test_random();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
